// File: rtl/ss_division_sequencer_if.sv
// Job/result handshake bundle for the stochastic divider sequencer.
// master: job issuer; slave: sequencer.
interface ss_division_sequencer_if #(
  parameter int LOG2_LEN = 8
);
  logic                start_valid;
  logic                start_ready;
  logic [7:0]          x_val;
  logic [7:0]          y_val;
  logic                res_valid;
  logic                res_ready;
  logic [LOG2_LEN+1:0] res_sum;
  logic [7:0]          res_quot;
  logic                res_div0;

  modport master (
    output start_valid, x_val, y_val, res_ready,
    input  start_ready, res_valid, res_sum, res_quot, res_div0
  );

  modport slave (
    input  start_valid, x_val, y_val, res_ready,
    output start_ready, res_valid, res_sum, res_quot, res_div0
  );
endinterface

// File: rtl/ss_division_sequencer.sv
// Sequences one stochastic-symbol division job: clear, warm-up, measure.
// Ports: clk, rst (async low), bus (job/result), rand_x/y, x_ss/y_ss, div_rst, z_ss.
module ss_division_sequencer #(
  parameter int WARMUP   = 64,
  parameter int LOG2_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  ss_division_sequencer_if.slave bus,
  input  logic [15:0] rand_x,
  input  logic [15:0] rand_y,
  output logic [1:0]  x_ss,
  output logic [1:0]  y_ss,
  output logic        div_rst,
  input  logic [1:0]  z_ss
);

  localparam int AW = LOG2_LEN + 2;
  localparam logic [15:0] WARM_LD =
    16'((WARMUP == 0) ? 0 : WARMUP - 1);
  localparam logic [15:0] MEAS_LD =
    16'((1 << LOG2_LEN) - 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, WARM, MEAS, DONE
  } state_t;

  state_t        state;
  logic [15:0]   cnt;
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;
  logic [AW-1:0] shr;
  logic [7:0]    quot_sat;
  logic [7:0]    x_q;
  logic [7:0]    y_q;
  logic          strm;

  function automatic logic [1:0] enc(
    input logic [15:0] r,
    input logic [7:0]  p
  );
    return {1'b0, r[7:0] < p} + {1'b0, r[15:8] < p};
  endfunction

  assign strm = (state == WARM) || (state == MEAS);
  assign x_ss = strm ? enc(rand_x, x_q) : 2'd0;
  assign y_ss = strm ? enc(rand_y, y_q) : 2'd0;

  assign acc_nxt = acc + {{LOG2_LEN{1'b0}}, z_ss};
  // Window sum can reach exactly 2^(LOG2_LEN+1), i.e. 256 after shift.
  assign shr = acc_nxt >> (LOG2_LEN - 7);
  assign quot_sat = (shr > AW'(255)) ? 8'hff : shr[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      cnt             <= '0;
      acc             <= '0;
      x_q             <= '0;
      y_q             <= '0;
      div_rst         <= 1'b1;
      bus.start_ready <= 1'b1;
      bus.res_valid   <= 1'b0;
      bus.res_sum     <= '0;
      bus.res_quot    <= '0;
      bus.res_div0    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start_valid) begin
            x_q             <= bus.x_val;
            y_q             <= bus.y_val;
            bus.start_ready <= 1'b0;
            if (bus.y_val == 8'd0) begin
              state         <= DONE;
              bus.res_valid <= 1'b1;
              bus.res_sum   <= '0;
              bus.res_quot  <= 8'hff;
              bus.res_div0  <= 1'b1;
            end else begin
              state   <= CLEAR;
              div_rst <= 1'b0;
            end
          end
        end
        CLEAR: begin
          div_rst <= 1'b1;
          acc     <= '0;
          if (WARMUP == 0) begin
            state <= MEAS;
            cnt   <= MEAS_LD;
          end else begin
            state <= WARM;
            cnt   <= WARM_LD;
          end
        end
        WARM: begin
          if (cnt == 16'd0) begin
            state <= MEAS;
            cnt   <= MEAS_LD;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        MEAS: begin
          acc <= acc_nxt;
          if (cnt == 16'd0) begin
            state         <= DONE;
            bus.res_valid <= 1'b1;
            bus.res_sum   <= acc_nxt;
            bus.res_quot  <= quot_sat;
            bus.res_div0  <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state           <= IDLE;
            bus.res_valid   <= 1'b0;
            bus.start_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_division_sequencer.sv
// Self-checking bench for ss_division_sequencer.
// Table-driven jobs with a cycle-indexed reference model.
module tb_ss_division_sequencer;

  localparam int W = 64;
  localparam int L = 8;
  localparam int N = 1 << L;

  logic        clk;
  logic        rst;
  logic [15:0] rand_x;
  logic [15:0] rand_y;
  logic [1:0]  x_ss;
  logic [1:0]  y_ss;
  logic        div_rst;
  logic [1:0]  z_ss;

  ss_division_sequencer_if #(.LOG2_LEN(L)) bif ();

  ss_division_sequencer #(.WARMUP(W), .LOG2_LEN(L)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .rand_x  (rand_x),
    .rand_y  (rand_y),
    .x_ss    (x_ss),
    .y_ss    (y_ss),
    .div_rst (div_rst),
    .z_ss    (z_ss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Number of random bytes in r that fall below probability p.
  function automatic int nsym(input logic [15:0] r, input logic [7:0] p);
    int n = 0;
    for (int i = 0; i < 2; i++)
      if (r[8*i +: 8] < p) n++;
    return n;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, " start_ready"}, bif.start_ready, 1);
    chk({tag, " x_ss"}, x_ss, 0);
    chk({tag, " y_ss"}, y_ss, 0);
    chk({tag, " div_rst"}, div_rst, 1);
    chk({tag, " res_valid"}, bif.res_valid, 0);
    chk({tag, " res_sum"}, bif.res_sum, 0);
    chk({tag, " res_quot"}, bif.res_quot, 0);
    chk({tag, " res_div0"}, bif.res_div0, 0);
  endtask

  // Runs one job starting just after a falling edge; returns just after
  // the falling edge of the cycle following the result handshake.
  task automatic run_job(input logic [7:0] x, input logic [7:0] y,
                         input int zk, input bit rnd, input int hold,
                         input int abort_at, input int exp_lat,
                         input int exp_quot);
    bit div0;
    int lat;
    int sum;
    int q;
    int xs_e;
    int ys_e;
    div0 = (y == 8'd0);
    lat  = div0 ? 1 : W + N + 2;
    sum  = 0;
    chk("latency", lat, exp_lat);
    bif.x_val       = x;
    bif.y_val       = y;
    bif.start_valid = 1'b1;
    bif.res_ready   = 1'b0;
    rand_x          = rnd ? 16'($urandom) : 16'd0;
    rand_y          = rnd ? 16'($urandom) : 16'd0;
    z_ss            = 2'd0;
    #1;
    chk("accept start_ready", bif.start_ready, 1);
    chk("idle x_ss", x_ss, 0);
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      bif.start_valid = 1'($urandom);
      bif.x_val       = 8'($urandom);
      bif.y_val       = 8'($urandom);
      rand_x = rnd ? 16'($urandom) : 16'd0;
      rand_y = rnd ? 16'($urandom) : 16'd0;
      z_ss   = (zk == 3) ? 2'($urandom_range(0, 2)) : 2'(zk);
      if (c == abort_at) begin
        rst = 1'b0;
        #1;
        chk_reset_vals("abort");
        #2;
        rst             = 1'b1;
        bif.start_valid = 1'b0;
        return;
      end
      #1;
      xs_e = (!div0 && c >= 2 && c <= W + N + 1) ? nsym(rand_x, x) : 0;
      ys_e = (!div0 && c >= 2 && c <= W + N + 1) ? nsym(rand_y, y) : 0;
      chk("x_ss", x_ss, xs_e);
      chk("y_ss", y_ss, ys_e);
      chk("div_rst", div_rst, (!div0 && c == 1) ? 0 : 1);
      chk("busy start_ready", bif.start_ready, 0);
      chk("res_valid timing", bif.res_valid, (c == lat) ? 1 : 0);
      if (!div0 && c >= W + 2 && c <= W + N + 1) sum += int'(z_ss);
    end
    q = div0 ? 255 : ((sum >> (L - 7)) > 255 ? 255 : (sum >> (L - 7)));
    if (exp_quot >= 0) chk("table quot", q, exp_quot);
    chk("res_sum", bif.res_sum, div0 ? 0 : sum);
    chk("res_quot", bif.res_quot, q);
    chk("res_div0", bif.res_div0, div0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bif.start_valid = 1'($urandom);
      bif.x_val       = 8'($urandom);
      bif.y_val       = 8'($urandom);
      #1;
      chk("hold res_valid", bif.res_valid, 1);
      chk("hold res_sum", bif.res_sum, div0 ? 0 : sum);
      chk("hold res_quot", bif.res_quot, q);
      chk("hold start_ready", bif.start_ready, 0);
    end
    bif.res_ready   = 1'b1;
    bif.start_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bif.res_ready = 1'b0;
    #1;
    chk("post start_ready", bif.start_ready, 1);
    chk("post res_valid", bif.res_valid, 0);
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int         zk;
    bit         rnd;
    int         hold;
    int         lat;
    int         quot;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'd0,   8'd128, 0, 1'b0, 3,  322, 0};
    tbl[1] = '{8'd64,  8'd128, 3, 1'b1, 0,  322, -1};
    tbl[2] = '{8'd200, 8'd200, 2, 1'b1, 50, 322, 255};
    tbl[3] = '{8'd37,  8'd0,   1, 1'b1, 5,  1,   255};
    tbl[4] = '{8'd255, 8'd255, 1, 1'b1, 0,  322, 128};
    tbl[5] = '{8'd128, 8'd7,   3, 1'b1, 2,  322, -1};

    rst             = 1'b0;
    bif.start_valid = 1'b0;
    bif.x_val       = 8'd0;
    bif.y_val       = 8'd0;
    bif.res_ready   = 1'b0;
    rand_x          = 16'hffff;
    rand_y          = 16'hffff;
    z_ss            = 2'd0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;

    foreach (tbl[i])
      run_job(tbl[i].x, tbl[i].y, tbl[i].zk, tbl[i].rnd, tbl[i].hold,
              -1, tbl[i].lat, tbl[i].quot);

    run_job(8'd90, 8'd180, 3, 1'b1, 0, 200, 322, -1);
    @(negedge clk);
    #1;
    chk_reset_vals("after abort");
    run_job(8'd90, 8'd180, 3, 1'b1, 1, -1, 322, -1);
    run_job(8'd1, 8'd0, 0, 1'b0, 0, -1, 1, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
